// File: rtl/exu_br_seq_ctl_pkg.sv
// Shared types for the non-speculative branch sequencer: state encoding and
// statistics-select codes.
package swerv_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } br_seq_state_t;

  localparam logic [1:0] BRS_RES   = 2'd0;
  localparam logic [1:0] BRS_FLUSH = 2'd1;
  localparam logic [1:0] BRS_STALL = 2'd2;
  localparam logic [1:0] BRS_TMO   = 2'd3;

endpackage

// File: rtl/exu_br_seq_ctl_if.sv
// Branch issue / ALU resolution / IFU flush bundle around exu_br_seq_ctl.
// master = decode+ALU side, slave = the sequencer.
interface exu_br_seq_ctl_if;
  logic        br_issue_i0;
  logic        br_issue_i1;
  logic        i0_valid_ff;
  logic        i0_pred_correct;
  logic        i0_flush_upper;
  logic [31:1] i0_flush_path;
  logic        i1_valid_ff;
  logic        i1_pred_correct;
  logic        i1_flush_upper;
  logic [31:1] i1_flush_path;
  logic        dec_br_stall;
  logic        exu_flush_upper;
  logic [31:1] exu_flush_path;

  modport master (
    output br_issue_i0, br_issue_i1,
    output i0_valid_ff, i0_pred_correct, i0_flush_upper, i0_flush_path,
    output i1_valid_ff, i1_pred_correct, i1_flush_upper, i1_flush_path,
    input  dec_br_stall, exu_flush_upper, exu_flush_path
  );

  modport slave (
    input  br_issue_i0, br_issue_i1,
    input  i0_valid_ff, i0_pred_correct, i0_flush_upper, i0_flush_path,
    input  i1_valid_ff, i1_pred_correct, i1_flush_upper, i1_flush_path,
    output dec_br_stall, exu_flush_upper, exu_flush_path
  );
endinterface

// File: rtl/exu_br_seq_ctl_stats.sv
// Saturating branch-resolution statistics bank with read mux; only built
// when RV_BR_SEQ_STATS_EN is defined.
module exu_br_seq_stats
  import swerv_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             stat_clr,
  input  logic [1:0]       inc_res,
  input  logic             inc_flush,
  input  logic             inc_stall,
  input  logic             inc_tmo,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_rd
);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // counter register bank
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // clear beats increment; freeze holds the bank
  always_comb begin
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    if (stat_clr) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
    end else if (freeze) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    end else begin
      cnt_d[BRS_RES]   = sat_add(cnt_q[BRS_RES],   inc_res);
      cnt_d[BRS_FLUSH] = sat_add(cnt_q[BRS_FLUSH], {1'b0, inc_flush});
      cnt_d[BRS_STALL] = sat_add(cnt_q[BRS_STALL], {1'b0, inc_stall});
      cnt_d[BRS_TMO]   = sat_add(cnt_q[BRS_TMO],   {1'b0, inc_tmo});
    end
  end

  // read mux
  always_comb begin
    case (stat_sel)
      BRS_RES:   stat_rd = cnt_q[BRS_RES];
      BRS_FLUSH: stat_rd = cnt_q[BRS_FLUSH];
      BRS_STALL: stat_rd = cnt_q[BRS_STALL];
      BRS_TMO:   stat_rd = cnt_q[BRS_TMO];
      default:   stat_rd = '0;
    endcase
  end

endmodule

// File: rtl/exu_br_seq_ctl.sv
// Non-speculative branch sequencer: stalls decode until i0/i1 resolve, picks the
// oldest redirect and drives one registered IFU flush. Stats gated by RV_BR_SEQ_STATS_EN.
module exu_br_seq_ctl
  import swerv_types::*;
#(
  parameter int TMO_W   = 6,
  parameter int TMO_MAX = 48,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 scan_mode,
  input  logic                 freeze,
  input  logic                 flush,
  exu_br_seq_ctl_if.slave      bus,
  output logic [1:0]           seq_state,
  output logic                 timeout_err,
  input  logic [1:0]           stat_sel,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_rd
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  br_seq_state_t    state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             flush_up_q, flush_up_d;
  logic [31:1]      flush_path_q, flush_path_d;
  logic             tmo_err_q, tmo_err_d;

  logic       issue_ev_s;
  logic       res0_s, res1_s;
  logic       fl0_s, fl1_s;
  logic [1:0] pend_nxt_s;
  logic       active_s;
  logic [1:0] inc_res_s;
  logic       inc_flush_s, inc_tmo_s, inc_stall_s;

  assign issue_ev_s = (bus.br_issue_i0 | bus.br_issue_i1) & ~flush & ~freeze;
  assign active_s   = (state_q == WAIT) & ~flush & ~freeze;
  assign res0_s     = active_s & bus.i0_valid_ff & pend_q[0] &
                      (bus.i0_pred_correct | bus.i0_flush_upper);
  assign res1_s     = active_s & bus.i1_valid_ff & pend_q[1] &
                      (bus.i1_pred_correct | bus.i1_flush_upper);
  assign fl0_s      = res0_s & bus.i0_flush_upper;
  assign fl1_s      = res1_s & bus.i1_flush_upper;
  assign pend_nxt_s = pend_q & ~{res1_s, res0_s};

  // state and output registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      pend_q       <= 2'b00;
      tmo_cnt_q    <= '0;
      flush_up_q   <= 1'b0;
      flush_path_q <= 31'd0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      tmo_cnt_q    <= tmo_cnt_d;
      flush_up_q   <= flush_up_d;
      flush_path_q <= flush_path_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  // next-state: commit flush beats freeze, freeze beats sequencing
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    tmo_cnt_d    = tmo_cnt_q;
    flush_up_d   = flush_up_q;
    flush_path_d = flush_path_q;
    tmo_err_d    = tmo_err_q;
    inc_flush_s  = 1'b0;
    inc_tmo_s    = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      pend_d     = 2'b00;
      flush_up_d = 1'b0;
    end else if (freeze) begin
      state_d    = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_ev_s) begin
            pend_d    = {bus.br_issue_i1, bus.br_issue_i0};
            tmo_cnt_d = '0;
            state_d   = WAIT;
          end else begin
            state_d   = IDLE;
          end
        end
        WAIT: begin
          if (fl0_s | fl1_s) begin
            // an i0 redirect also kills the younger i1 branch
            state_d      = FLUSH;
            flush_path_d = fl0_s ? bus.i0_flush_path : bus.i1_flush_path;
            pend_d       = fl0_s ? 2'b00 : pend_nxt_s;
            inc_flush_s  = 1'b1;
          end else if (pend_nxt_s == 2'b00) begin
            state_d = IDLE;
            pend_d  = 2'b00;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_d   = IDLE;
            pend_d    = 2'b00;
            tmo_err_d = 1'b1;
            inc_tmo_s = 1'b1;
          end else begin
            pend_d    = pend_nxt_s;
            tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        FLUSH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          pend_d  = 2'b00;
        end
      endcase
      flush_up_d = (state_d == FLUSH);
    end
  end

  assign bus.dec_br_stall    = (state_q != IDLE) | issue_ev_s;
  assign bus.exu_flush_upper = flush_up_q;
  assign bus.exu_flush_path  = flush_path_q;
  assign seq_state           = state_q;
  assign timeout_err         = tmo_err_q;

  assign inc_res_s   = {1'b0, res0_s} + {1'b0, res1_s};
  assign inc_stall_s = bus.dec_br_stall & ~freeze;

`ifdef RV_BR_SEQ_STATS_EN
  exu_br_seq_stats #(.CNT_W(CNT_W)) u_stats (
    .clk       (clk),
    .rst_l     (rst_l),
    .freeze    (freeze),
    .stat_clr  (stat_clr),
    .inc_res   (inc_res_s),
    .inc_flush (inc_flush_s),
    .inc_stall (inc_stall_s),
    .inc_tmo   (inc_tmo_s),
    .stat_sel  (stat_sel),
    .stat_rd   (stat_rd)
  );
  logic unused_ok;
  assign unused_ok = scan_mode;
`else
  assign stat_rd = '0;
  logic unused_ok;
  assign unused_ok = ^{scan_mode, stat_sel, stat_clr, inc_res_s,
                       inc_flush_s, inc_stall_s, inc_tmo_s};
`endif

endmodule

// File: tb/tb_exu_br_seq_ctl.sv
// Directed self-checking bench for exu_br_seq_ctl; statistics checks follow
// RV_BR_SEQ_STATS_EN, otherwise stat_rd is expected to read 0.
module tb_exu_br_seq_ctl;
  import swerv_types::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             scan_mode;
  logic             freeze;
  logic             flush;
  logic [1:0]       seq_state;
  logic             timeout_err;
  logic [1:0]       stat_sel;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_rd;

  int passed = 0;
  int total  = 0;

  exu_br_seq_ctl_if bif ();

  exu_br_seq_ctl #(.TMO_W(6), .TMO_MAX(48), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .scan_mode   (scan_mode),
    .freeze      (freeze),
    .flush       (flush),
    .bus         (bif.slave),
    .seq_state   (seq_state),
    .timeout_err (timeout_err),
    .stat_sel    (stat_sel),
    .stat_clr    (stat_clr),
    .stat_rd     (stat_rd)
  );

  always #5 clk = ~clk;

  // decode must not issue while a branch is outstanding
  always @(posedge clk) begin
    if (rst_l && (bif.br_issue_i0 || bif.br_issue_i1) && !freeze && !flush && seq_state != 2'd0)
      $error("branch issued outside IDLE");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.br_issue_i0 = 1'b0;  bif.br_issue_i1 = 1'b0;
    bif.i0_valid_ff = 1'b0;  bif.i0_pred_correct = 1'b0;
    bif.i0_flush_upper = 1'b0; bif.i0_flush_path = 31'd0;
    bif.i1_valid_ff = 1'b0;  bif.i1_pred_correct = 1'b0;
    bif.i1_flush_upper = 1'b0; bif.i1_flush_path = 31'd0;
    freeze = 1'b0; flush = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic clr_stats();
    stat_clr = 1'b1;
    nxt();
    stat_clr = 1'b0;
  endtask

  task automatic check_stat(input logic [1:0] sel, input logic [CNT_W-1:0] want, input string name);
    logic [CNT_W-1:0] exp_v;
    stat_sel = sel;
    #1;
`ifdef RV_BR_SEQ_STATS_EN
    exp_v = want;
`else
    exp_v = {CNT_W{1'b0}};
`endif
    total++;
    if (stat_rd !== exp_v) $display("FAIL %s: stat_rd=%0d expected %0d", name, stat_rd, exp_v);
    else passed++;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; scan_mode = 1'b0; stat_sel = 2'd0;
    idle_inputs();
    nxt(); nxt();
    @(negedge clk);
    total++; if (seq_state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", seq_state); else passed++;
    total++; if (bif.exu_flush_upper !== 1'b0) $display("FAIL rst_fu: got %0b expected 0", bif.exu_flush_upper); else passed++;
    total++; if (bif.exu_flush_path !== 31'd0) $display("FAIL rst_path: got %0h expected 0", bif.exu_flush_path); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_tmo: got %0b expected 0", timeout_err); else passed++;
    total++; if (bif.dec_br_stall !== 1'b0) $display("FAIL rst_stall: got %0b expected 0", bif.dec_br_stall); else passed++;
    check_stat(BRS_STALL, 4'd0, "rst_stat");
    @(posedge clk); #1;
    rst_l = 1'b1;
    nxt();
  endtask

  // i0 issue, correct resolve three cycles later
  task automatic test_correct_i0();
    int stall_n = 0;
    int fu_n = 0;
    clr_stats();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i == 0) bif.br_issue_i0 = 1'b1;
      if (i == 3) begin bif.i0_valid_ff = 1'b1; bif.i0_pred_correct = 1'b1; end
      @(negedge clk);
      if (bif.dec_br_stall) stall_n++;
      if (bif.exu_flush_upper) fu_n++;
      @(posedge clk); #1;
    end
    total++; if (stall_n != 4) $display("FAIL corr_stall_len: got %0d expected 4", stall_n); else passed++;
    total++; if (fu_n != 0) $display("FAIL corr_no_flush: got %0d pulses expected 0", fu_n); else passed++;
    total++; if (seq_state !== 2'd0) $display("FAIL corr_idle: got %0d expected 0", seq_state); else passed++;
    check_stat(BRS_RES, 4'd1, "corr_stat_res");
  endtask

  // both pipes redirect together; i0 must win
  task automatic test_dual_flush();
    logic [31:0] pc0 = 32'h0000_0100;
    logic [31:0] pc1 = 32'h0000_0200;
    clr_stats();
    idle_inputs();
    bif.br_issue_i0 = 1'b1; bif.br_issue_i1 = 1'b1;
    nxt();
    idle_inputs();
    bif.i0_valid_ff = 1'b1; bif.i0_flush_upper = 1'b1; bif.i0_flush_path = pc0[31:1];
    bif.i1_valid_ff = 1'b1; bif.i1_flush_upper = 1'b1; bif.i1_flush_path = pc1[31:1];
    @(negedge clk);
    total++; if (seq_state !== 2'd1) $display("FAIL dual_wait: got %0d expected 1", seq_state); else passed++;
    nxt();
    idle_inputs();
    @(negedge clk);
    total++; if (bif.exu_flush_upper !== 1'b1) $display("FAIL dual_fu: got %0b expected 1", bif.exu_flush_upper); else passed++;
    total++; if (bif.exu_flush_path !== pc0[31:1]) $display("FAIL dual_path: got %0h expected %0h", bif.exu_flush_path, pc0[31:1]); else passed++;
    total++; if (bif.dec_br_stall !== 1'b1) $display("FAIL dual_stall_hold: got %0b expected 1", bif.dec_br_stall); else passed++;
    nxt();
    @(negedge clk);
    total++; if (bif.exu_flush_upper !== 1'b0) $display("FAIL dual_fu_once: got %0b expected 0", bif.exu_flush_upper); else passed++;
    total++; if (bif.dec_br_stall !== 1'b0) $display("FAIL dual_stall_rel: got %0b expected 0", bif.dec_br_stall); else passed++;
    total++; if (seq_state !== 2'd0) $display("FAIL dual_idle: got %0d expected 0", seq_state); else passed++;
    nxt();
    check_stat(BRS_FLUSH, 4'd1, "dual_stat_flush");
    check_stat(BRS_RES, 4'd2, "dual_stat_res");
  endtask

  // i1 redirect held through two freeze cycles
  task automatic test_freeze();
    logic [31:0] pc1 = 32'h4000_0010;
    idle_inputs();
    bif.br_issue_i1 = 1'b1;
    nxt();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      freeze = (i < 2) ? 1'b1 : 1'b0;
      bif.i1_valid_ff = 1'b1; bif.i1_flush_upper = 1'b1; bif.i1_flush_path = pc1[31:1];
      @(negedge clk);
      total++; if (seq_state !== 2'd1 || bif.exu_flush_upper !== 1'b0)
        $display("FAIL frz_hold%0d: state=%0d fu=%0b expected 1/0", i, seq_state, bif.exu_flush_upper);
      else passed++;
      nxt();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (bif.exu_flush_upper !== 1'b1) $display("FAIL frz_fu: got %0b expected 1", bif.exu_flush_upper); else passed++;
    total++; if (bif.exu_flush_path !== pc1[31:1]) $display("FAIL frz_path: got %0h expected %0h", bif.exu_flush_path, pc1[31:1]); else passed++;
    nxt();
    @(negedge clk);
    total++; if (seq_state !== 2'd0) $display("FAIL frz_idle: got %0d expected 0", seq_state); else passed++;
    nxt();
  endtask

  // commit flush arriving with an i0 redirect cancels it
  task automatic test_flush_kill();
    logic [31:0] pc0 = 32'h0000_0abc;
    logic [31:0] old_pc = 32'h4000_0010;
    idle_inputs();
    bif.br_issue_i0 = 1'b1;
    nxt();
    idle_inputs();
    flush = 1'b1;
    bif.i0_valid_ff = 1'b1; bif.i0_flush_upper = 1'b1; bif.i0_flush_path = pc0[31:1];
    nxt();
    idle_inputs();
    @(negedge clk);
    total++; if (bif.exu_flush_upper !== 1'b0) $display("FAIL kill_fu: got %0b expected 0", bif.exu_flush_upper); else passed++;
    total++; if (seq_state !== 2'd0) $display("FAIL kill_idle: got %0d expected 0", seq_state); else passed++;
    total++; if (bif.exu_flush_path !== old_pc[31:1]) $display("FAIL kill_path: got %0h expected %0h", bif.exu_flush_path, old_pc[31:1]); else passed++;
    nxt();
  endtask

  // resolve on a non-pending pipe is ignored; back-to-back issue after resolve
  task automatic test_back_to_back();
    idle_inputs();
    bif.br_issue_i0 = 1'b1;
    nxt();
    idle_inputs();
    bif.i1_valid_ff = 1'b1; bif.i1_flush_upper = 1'b1; bif.i1_flush_path = 31'h1234;
    nxt();
    idle_inputs();
    @(negedge clk);
    total++; if (seq_state !== 2'd1) $display("FAIL nonpend_wait: got %0d expected 1", seq_state); else passed++;
    bif.i0_valid_ff = 1'b1; bif.i0_pred_correct = 1'b1;
    nxt();
    idle_inputs();
    bif.br_issue_i1 = 1'b1;
    @(negedge clk);
    total++; if (bif.dec_br_stall !== 1'b1 || seq_state !== 2'd0)
      $display("FAIL b2b_issue: stall=%0b state=%0d expected 1/0", bif.dec_br_stall, seq_state);
    else passed++;
    nxt();
    idle_inputs();
    bif.i1_valid_ff = 1'b1; bif.i1_pred_correct = 1'b1;
    @(negedge clk);
    total++; if (seq_state !== 2'd1) $display("FAIL b2b_wait: got %0d expected 1", seq_state); else passed++;
    nxt();
    idle_inputs();
    nxt();
  endtask

  // unresolved branch times out; stall counter saturates, then clear wins
  task automatic test_timeout();
    int n = 0;
    clr_stats();
    idle_inputs();
    bif.br_issue_i0 = 1'b1;
    nxt();
    idle_inputs();
    while (seq_state == 2'd1 && n < 60) begin
      n++;
      nxt();
    end
    total++; if (n != 48) $display("FAIL tmo_len: got %0d wait cycles expected 48", n); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL tmo_err: got %0b expected 1", timeout_err); else passed++;
    total++; if (seq_state !== 2'd0) $display("FAIL tmo_idle: got %0d expected 0", seq_state); else passed++;
    total++; if (bif.dec_br_stall !== 1'b0) $display("FAIL tmo_stall: got %0b expected 0", bif.dec_br_stall); else passed++;
    check_stat(BRS_TMO, 4'd1, "tmo_stat");
    check_stat(BRS_STALL, 4'hf, "stall_sat");
    bif.br_issue_i0 = 1'b1; stat_clr = 1'b1;
    nxt();
    idle_inputs();
    check_stat(BRS_STALL, 4'd0, "clr_wins");
    bif.i0_valid_ff = 1'b1; bif.i0_pred_correct = 1'b1;
    nxt();
    idle_inputs();
    @(negedge clk);
    total++; if (seq_state !== 2'd0 || timeout_err !== 1'b1)
      $display("FAIL tmo_sticky: state=%0d err=%0b expected 0/1", seq_state, timeout_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_correct_i0();
    test_dual_flush();
    test_freeze();
    test_flush_kill();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
